// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants, tx state encoding and header builder for router_pkt_tx
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int LEN_W     = 6;
    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 1 << LEN_W;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t TX_IDLE    = 3'd0;
    localparam tx_state_t TX_LOAD    = 3'd1;
    localparam tx_state_t TX_HEADER  = 3'd2;
    localparam tx_state_t TX_PAYLOAD = 3'd3;
    localparam tx_state_t TX_PARITY  = 3'd4;

    // Header layout the router decodes: length in the top bits, destination in the low two.
    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0] len,
                                                      input logic [1:0]       dest);
        return {len, dest};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - 64x8 payload buffer, synchronous write, asynchronous read
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [LEN_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [LEN_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffered packet source for one router input port; ROUTER_TX_STATS_EN adds pkt/stall counters
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_dest,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_done,
    output logic              cmd_err,
`ifdef ROUTER_TX_STATS_EN
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       stall_cnt,
`endif
    output logic              tx_active
);

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        dest_q, dest_d;
    logic [LEN_W-1:0]  wptr_q, wptr_d;
    logic [LEN_W-1:0]  rptr_q, rptr_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              tx_done_q, tx_done_d;
    logic              cmd_err_q, cmd_err_d;
    logic              buf_we;
    logic [DATA_W-1:0] buf_rdata;

    router_tx_buf u_buf (
        .clk     (clk),
        .wr_en_i (buf_we),
        .waddr_i (wptr_q),
        .wdata_i (pl_data),
        .raddr_i (rptr_q),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        dest_d      = dest_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        parity_d    = parity_q;
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        tx_done_d   = 1'b0;
        cmd_err_d   = 1'b0;
        buf_we      = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0 || int'(cmd_dest) >= NUM_PORTS) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        len_d    = cmd_len;
                        dest_d   = cmd_dest;
                        parity_d = make_header(cmd_len, cmd_dest);
                        wptr_d   = '0;
                        rptr_d   = '0;
                        state_d  = TX_LOAD;
                    end
                end
            end
            TX_LOAD: begin
                if (pl_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ pl_data;
                    wptr_d   = wptr_q + LEN_W'(1);
                    if (wptr_q == len_q - LEN_W'(1)) begin
                        state_d     = TX_HEADER;
                        pkt_valid_d = 1'b1;
                        data_d      = make_header(len_q, dest_q);
                    end
                end
            end
            TX_HEADER: begin
                if (!busy) begin
                    data_d  = buf_rdata;
                    rptr_d  = rptr_q + LEN_W'(1);
                    state_d = TX_PAYLOAD;
                end
            end
            TX_PAYLOAD: begin
                // rptr points at the next unsent byte, so rptr==len means the last byte is on the wire
                if (!busy) begin
                    if (rptr_q == len_q) begin
                        pkt_valid_d = 1'b0;
                        data_d      = parity_q;
                        state_d     = TX_PARITY;
                    end else begin
                        data_d = buf_rdata;
                        rptr_d = rptr_q + LEN_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (!busy) begin
                    data_d    = '0;
                    tx_done_d = 1'b1;
                    state_d   = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= TX_IDLE;
            len_q       <= '0;
            dest_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            parity_q    <= '0;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            tx_done_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            dest_q      <= dest_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            parity_q    <= parity_d;
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            tx_done_q   <= tx_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign cmd_ready = (state_q == TX_IDLE);
    assign pl_ready  = (state_q == TX_LOAD);
    assign tx_active = (state_q != TX_IDLE);
    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_q;
    assign tx_done   = tx_done_q;
    assign cmd_err   = cmd_err_q;

`ifdef ROUTER_TX_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        on_wire;

    assign on_wire = (state_q == TX_HEADER) || (state_q == TX_PAYLOAD) || (state_q == TX_PARITY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (tx_done_d && pkt_cnt_q != 16'hFFFF) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (on_wire && busy && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - self-checking bench for router_pkt_tx with a queue-based packet model
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dest = '0;
    logic [5:0] cmd_len = '0;
    logic       pl_valid = 1'b0;
    logic [7:0] pl_data = '0;
    logic       busy = 1'b0;
    logic       cmd_ready, pl_ready, pkt_valid, tx_done, cmd_err, tx_active;
    logic [7:0] data_out;
`ifdef ROUTER_TX_STATS_EN
    logic [15:0] pkt_cnt, stall_cnt;
`endif

    router_pkt_tx dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dest  (cmd_dest),
        .cmd_len   (cmd_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .tx_done   (tx_done),
        .cmd_err   (cmd_err),
`ifdef ROUTER_TX_STATS_EN
        .pkt_cnt   (pkt_cnt),
        .stall_cnt (stall_cnt),
`endif
        .tx_active (tx_active)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] expq[$];
    logic [7:0] obs[$];
    logic [7:0] payload [64];
    bit         loading = 1'b0;
    bit         done_flag = 1'b0;
    bit         exp_err = 1'b0;
    int         model_pkts = 0;
    int         model_stalls = 0;
    int         cur_dest = 0;
    int         cur_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected wire image of one packet: header, payload in order, XOR of everything before it.
    function automatic void push_pkt(input int dest, input int len);
        logic [7:0] hdr;
        logic [7:0] par;
        hdr = 8'(len * 4 + dest);
        par = hdr;
        expq.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            expq.push_back(payload[i]);
            par = par ^ payload[i];
        end
        expq.push_back(par);
    endfunction

    always @(negedge clk) begin
        bit active;
        active = loading || (expq.size() != 0);
        chk("tx_done", 32'(tx_done), 32'(done_flag));
        done_flag = 1'b0;
        chk("cmd_err", 32'(cmd_err), 32'(exp_err));
        chk("cmd_ready", 32'(cmd_ready), 32'(!active));
        chk("tx_active", 32'(tx_active), 32'(active));
        chk("pl_ready", 32'(pl_ready), 32'(loading));
        if (expq.size() == 0) begin
            chk("pkt_valid_idle", 32'(pkt_valid), 32'd0);
            chk("data_out_idle", 32'(data_out), 32'd0);
        end else begin
            chk("pkt_valid", 32'(pkt_valid), 32'(expq.size() > 1));
            chk("data_out", 32'(data_out), 32'(expq[0]));
            if (busy) begin
                model_stalls++;
            end else begin
                obs.push_back(data_out);
                void'(expq.pop_front());
                if (expq.size() == 0) begin
                    done_flag = 1'b1;
                    model_pkts++;
                end
            end
        end
    end

    task automatic send_cmd(input int d, input int l, input bit ok);
        cmd_valid = 1'b1;
        cmd_dest  = d[1:0];
        cmd_len   = l[5:0];
        cur_dest  = d;
        cur_len   = l;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (ok) begin
            loading = 1'b1;
        end else begin
            exp_err = 1'b1;
            @(posedge clk); #1;
            exp_err = 1'b0;
        end
    endtask

    task automatic load_payload();
        for (int i = 0; i < cur_len; i++) begin
            pl_valid = 1'b1;
            pl_data  = payload[i];
            @(posedge clk); #1;
        end
        pl_valid = 1'b0;
        loading  = 1'b0;
        push_pkt(cur_dest, cur_len);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((expq.size() != 0 || !done_flag) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_done_in_budget", 32'(n < 1000), 32'd1);
    endtask

    task automatic check_obs1(input string name);
        logic [7:0] lit [5];
        lit = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
        chk({name, "_len"}, 32'(obs.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            chk(name, 32'(obs[i]), 32'(lit[i]));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_pl_ready", 32'(pl_ready), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // payload strobes in IDLE must be ignored
        pl_valid = 1'b1;
        pl_data  = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        pl_valid = 1'b0;

        payload[0] = 8'hA1;
        payload[1] = 8'hB2;
        payload[2] = 8'hC3;
        obs.delete();
        send_cmd(1, 3, 1'b1);
        load_payload();
        wait_done();
        check_obs1("pkt1_stream");
        repeat (2) @(posedge clk);
        #1;

        obs.delete();
        send_cmd(1, 3, 1'b1);
        load_payload();
        busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        busy = 1'b0;
        wait_done();
        check_obs1("pkt2_stream");
`ifdef ROUTER_TX_STATS_EN
        chk("stall_cnt_busy3", 32'(stall_cnt), 32'd3);
`endif
        chk("model_stalls_busy3", 32'(model_stalls), 32'd3);
        @(posedge clk); #1;

        send_cmd(3, 5, 1'b0);
        send_cmd(0, 0, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 63; i++) payload[i] = 8'(i);
        obs.delete();
        send_cmd(2, 63, 1'b1);
        load_payload();
        // a command while transmitting is not looked at, so no error pulse
        cmd_valid = 1'b1;
        cmd_dest  = 2'd3;
        cmd_len   = 6'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done();
        chk("len63_count", 32'(obs.size()), 32'd65);
        if (obs.size() == 65) begin
            chk("len63_header", 32'(obs[0]), 32'hFE);
            chk("len63_last_payload", 32'(obs[63]), 32'd62);
            chk("len63_parity", 32'(obs[64]), 32'hC1);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) payload[i] = 8'h10 + 8'(i);
        send_cmd(0, 4, 1'b1);
        load_payload();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        expq.delete();
        done_flag    = 1'b0;
        model_pkts   = 0;
        model_stalls = 0;
        #1;
        chk("midrst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        chk("midrst_tx_active", 32'(tx_active), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        payload[0] = 8'h3C;
        payload[1] = 8'h5A;
        send_cmd(0, 2, 1'b1);
        load_payload();
        wait_done();
        payload[0] = 8'h77;
        send_cmd(1, 1, 1'b1);
        load_payload();
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("model_pkts_b2b", 32'(model_pkts), 32'd2);
`ifdef ROUTER_TX_STATS_EN
        chk("pkt_cnt_b2b", 32'(pkt_cnt), 32'd2);
        chk("stall_cnt_model", 32'(stall_cnt), 32'(model_stalls));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
